// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the single-cycle MIPS core: instruction RAM,
// data RAM, MMIO window (LED, switches, cycle counter), and a byte-stream
// boot loader that holds the core in reset until the image is loaded.
module cpu_mem_responder #(
  parameter int unsigned IMEM_AW   = 10,
  parameter int unsigned DMEM_AW   = 10,
  parameter logic [31:0] IMEM_BASE = 32'h00400000,
  parameter logic [31:0] DMEM_BASE = 32'h10010000,
  parameter bit          SKIP_LOAD = 1'b0
) (
  input  logic        clk3,
  input  logic        rst,
  output logic        cpu_rst,
  input  logic [31:0] addr_imem,
  output logic [31:0] data_imem,
  input  logic [31:0] addr_dmem,
  inout  logic [31:0] data_dmem,
  input  logic        wea_dmem,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        ld_overflow,
  output logic [15:0] led,
  input  logic [15:0] sw
);

  typedef enum logic [1:0] {HDR0, HDR1, DATA, RUN} state_t;

  localparam state_t      RESET_STATE = SKIP_LOAD ? RUN : HDR0;
  localparam int unsigned IMEM_DEPTH  = 1 << IMEM_AW;
  localparam logic [31:0] LED_ADDR    = 32'hFFFF0000;
  localparam logic [31:0] SW_ADDR     = 32'hFFFF0004;
  localparam logic [31:0] CYC_ADDR    = 32'hFFFF0008;

  state_t      state, state_next;
  logic [15:0] n;
  logic [15:0] wcnt;
  logic [1:0]  bcnt;
  logic [31:0] asm_word;
  logic [31:0] cycles;
  logic        take;
  logic        word_done;
  logic        wcnt_ovf;
  logic [31:0] load_word;
  logic [31:0] rdata;
  logic        wr;
  logic        imem_hit, dmem_hit;
  logic        unused_addr_lsb;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [1 << DMEM_AW];

  assign unused_addr_lsb = ^{addr_imem[1:0], addr_dmem[1:0]};

  assign ld_ready  = (state != RUN);
  assign wcnt_ovf  = (32'(wcnt) >= IMEM_DEPTH);
  // Bytes shift in from the top, so after four bytes the first lands in [7:0].
  assign load_word = {ld_byte, asm_word[31:8]};

  // Loader state register.
  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  // Loader next-state and byte-accept decode.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    word_done  = 1'b0;
    case (state)
      HDR0: if (ld_valid) begin
        take       = 1'b1;
        state_next = HDR1;
      end
      HDR1: if (ld_valid) begin
        take       = 1'b1;
        state_next = ({ld_byte, n[7:0]} == 16'h0) ? RUN : DATA;
      end
      DATA: if (ld_valid) begin
        take = 1'b1;
        if (bcnt == 2'd3) begin
          word_done = 1'b1;
          if (wcnt == n - 16'd1) state_next = RUN;
        end
      end
      default: ;
    endcase
  end

  // Loader datapath: header, word assembly, counters, overflow, core reset.
  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) begin
      n           <= '0;
      wcnt        <= '0;
      bcnt        <= '0;
      asm_word    <= '0;
      ld_overflow <= 1'b0;
      cpu_rst     <= !SKIP_LOAD;
    end else begin
      if (state_next == RUN) cpu_rst <= 1'b0;
      if (take) begin
        case (state)
          HDR0: n[7:0]  <= ld_byte;
          HDR1: n[15:8] <= ld_byte;
          DATA: begin
            bcnt     <= bcnt + 2'd1;
            asm_word <= load_word;
            if (word_done) begin
              wcnt <= wcnt + 16'd1;
              if (wcnt_ovf) ld_overflow <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Instruction RAM fill from the loader; words past the RAM depth are dropped.
  always_ff @(posedge clk3) begin
    if (word_done && !wcnt_ovf) imem[wcnt[IMEM_AW-1:0]] <= load_word;
  end

  assign imem_hit  = (addr_imem[31:IMEM_AW+2] == IMEM_BASE[31:IMEM_AW+2]);
  assign data_imem = (imem_hit && state == RUN) ? imem[addr_imem[IMEM_AW+1:2]] : '0;

  assign dmem_hit = (addr_dmem[31:DMEM_AW+2] == DMEM_BASE[31:DMEM_AW+2]);
  assign wr       = wea_dmem && (state == RUN);

  // Data-side read decode.
  always_comb begin
    rdata = '0;
    if (dmem_hit)                              rdata = dmem[addr_dmem[DMEM_AW+1:2]];
    else if (addr_dmem[31:2] == LED_ADDR[31:2]) rdata = {16'h0, led};
    else if (addr_dmem[31:2] == SW_ADDR[31:2])  rdata = {16'h0, sw};
    else if (addr_dmem[31:2] == CYC_ADDR[31:2]) rdata = cycles;
  end

  assign data_dmem = (!cpu_rst && !wea_dmem) ? rdata : 'z;

  // Data RAM store port.
  always_ff @(posedge clk3) begin
    if (wr && dmem_hit) dmem[addr_dmem[DMEM_AW+1:2]] <= data_dmem;
  end

  // LED register and free-running cycle counter.
  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) begin
      led    <= '0;
      cycles <= '0;
    end else begin
      if (wr && addr_dmem[31:2] == LED_ADDR[31:2]) led <= data_dmem[15:0];
      if (state == RUN) cycles <= cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: loader sequences from a vector table,
// then data-side and MMIO sequences, then an overflow boot on a small-IMEM copy.
module tb_cpu_mem_responder;

  logic        clk3, rst;
  logic        cpu_rst, ld_ready, ld_overflow, ld_valid;
  logic [31:0] addr_imem, data_imem, addr_dmem, wdata;
  logic        wea_dmem, drv;
  logic [7:0]  ld_byte;
  logic [15:0] led, sw;
  wire  [31:0] bus;

  logic        cpu_rst2, ld_ready2, ld_overflow2, ld_valid2;
  logic [31:0] addr_imem2, data_imem2, addr_dmem2;
  logic [7:0]  ld_byte2;
  logic [15:0] led2, sw2;
  wire  [31:0] bus2;

  int n_cmp = 0;
  int n_bad = 0;

  pullup (bus);
  pullup (bus2);
  assign bus = drv ? wdata : 'z;

  cpu_mem_responder dut (
    .clk3(clk3), .rst(rst), .cpu_rst(cpu_rst),
    .addr_imem(addr_imem), .data_imem(data_imem),
    .addr_dmem(addr_dmem), .data_dmem(bus), .wea_dmem(wea_dmem),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
    .ld_overflow(ld_overflow), .led(led), .sw(sw)
  );

  cpu_mem_responder #(.IMEM_AW(2)) dut2 (
    .clk3(clk3), .rst(rst), .cpu_rst(cpu_rst2),
    .addr_imem(addr_imem2), .data_imem(data_imem2),
    .addr_dmem(addr_dmem2), .data_dmem(bus2), .wea_dmem(1'b0),
    .ld_valid(ld_valid2), .ld_byte(ld_byte2), .ld_ready(ld_ready2),
    .ld_overflow(ld_overflow2), .led(led2), .sw(sw2)
  );

  initial begin
    clk3 = 1'b0;
    forever #5 clk3 = ~clk3;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        do_rst;
    logic        valid;
    logic [7:0]  b;
    logic [31:0] iaddr;
    logic        exp_cpu_rst;
    logic        exp_ready;
    logic [31:0] exp_imem;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] IB = 32'h00400000;

  logic [31:0] c1, c2;

  initial begin
    // Boot two words with stalls mid-word.
    vecs.push_back('{1'b0, 1'b1, 8'h02, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h13, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 8'hEE, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h08, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 8'h77, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h20, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b0, 1'b0, 32'h20080013});
    // RUN ignores loader bytes; fetch decode hit/miss.
    vecs.push_back('{1'b0, 1'b1, 8'h55, IB + 32'd4, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 32'h00800000, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, IB, 1'b0, 1'b0, 32'h20080013});
    // Reset, then a partial word followed by reset mid-load.
    vecs.push_back('{1'b1, 1'b0, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h01, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'hAA, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'hBB, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'hCC, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    // N=0 header: straight to RUN, earlier image still in place.
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, IB, 1'b0, 1'b0, 32'h20080013});
    vecs.push_back('{1'b0, 1'b0, 8'h00, IB + 32'd4, 1'b0, 1'b0, 32'h0});

    rst = 1'b1; ld_valid = 1'b0; ld_byte = '0; addr_imem = IB;
    addr_dmem = 32'hFFFF0008; wea_dmem = 1'b0; drv = 1'b0; wdata = '0; sw = '0;
    ld_valid2 = 1'b0; ld_byte2 = '0; addr_imem2 = IB; addr_dmem2 = '0; sw2 = '0;
    #12;
    chk("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    chk("rst_ready", {31'b0, ld_ready}, 32'd1);
    chk("rst_overflow", {31'b0, ld_overflow}, 32'd0);
    chk("rst_led", {16'b0, led}, 32'd0);
    chk("rst_bus_hiz", bus, 32'hFFFFFFFF);
    @(negedge clk3);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk3);
      addr_imem = vecs[i].iaddr;
      if (vecs[i].do_rst) begin
        ld_valid = 1'b0;
        rst = 1'b1;
        #2;
      end else begin
        ld_valid = vecs[i].valid;
        ld_byte  = vecs[i].b;
        @(posedge clk3);
        #1;
      end
      chk($sformatf("v%0d_cpu_rst", i), {31'b0, cpu_rst}, {31'b0, vecs[i].exp_cpu_rst});
      chk($sformatf("v%0d_ready", i), {31'b0, ld_ready}, {31'b0, vecs[i].exp_ready});
      chk($sformatf("v%0d_imem", i), data_imem, vecs[i].exp_imem);
      rst = 1'b0;
    end
    ld_valid = 1'b0;

    // One edge in RUN after the entry edge.
    #1 chk("cyc_first", bus, 32'd1);

    // Data RAM store then load; bus released while wea is high.
    @(negedge clk3);
    addr_dmem = 32'h10010004; wea_dmem = 1'b1; drv = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk3);
    #1 drv = 1'b0;
    #1 chk("wea_hiz", bus, 32'hFFFFFFFF);
    wea_dmem = 1'b0;
    #1 chk("dmem_load", bus, 32'hDEADBEEF);
    addr_dmem = 32'h10010007;
    #1 chk("dmem_lsb_ignored", bus, 32'hDEADBEEF);
    addr_dmem = 32'h10010000;
    #1 chk("dmem_other_word", bus === 32'hDEADBEEF ? 32'd1 : 32'd0, 32'd0);

    // LED store and readback.
    @(negedge clk3);
    addr_dmem = 32'hFFFF0000; wea_dmem = 1'b1; drv = 1'b1; wdata = 32'h1234ABCD;
    @(posedge clk3);
    #1 drv = 1'b0; wea_dmem = 1'b0;
    chk("led_reg", {16'b0, led}, 32'h0000ABCD);
    #1 chk("led_load", bus, 32'h0000ABCD);

    // Switches, including an ignored store to the read-only register.
    sw = 16'h00F0;
    @(negedge clk3);
    addr_dmem = 32'hFFFF0004; wea_dmem = 1'b1; drv = 1'b1; wdata = 32'h0000FFFF;
    @(posedge clk3);
    #1 drv = 1'b0; wea_dmem = 1'b0;
    #1 chk("sw_load", bus, 32'h000000F0);

    // Cycle counter two edges apart.
    @(negedge clk3);
    addr_dmem = 32'hFFFF0008;
    #1 c1 = bus;
    @(negedge clk3);
    @(negedge clk3);
    #1 c2 = bus;
    chk("cyc_delta", c2 - c1, 32'd2);

    // Unmapped store is dropped, unmapped load reads zero.
    @(negedge clk3);
    addr_dmem = 32'h20000000; wea_dmem = 1'b1; drv = 1'b1; wdata = 32'h55555555;
    @(posedge clk3);
    #1 drv = 1'b0; wea_dmem = 1'b0;
    #1 chk("unmapped_load", bus, 32'h0);
    addr_dmem = 32'h10010004;
    #1 chk("dmem_after_unmapped", bus, 32'hDEADBEEF);

    // Overflow: N=5 into a four-word IMEM; word k carries value k+1.
    for (int s = 0; s < 22; s++) begin
      @(negedge clk3);
      ld_valid2 = 1'b1;
      if (s == 0)             ld_byte2 = 8'h05;
      else if (s == 1)        ld_byte2 = 8'h00;
      else if ((s - 2) % 4 == 0) ld_byte2 = 8'((s - 2) / 4 + 1);
      else                    ld_byte2 = 8'h00;
      @(posedge clk3);
      #1;
      if (s == 17) chk("ovf_not_yet", {31'b0, ld_overflow2}, 32'd0);
      if (s == 20) chk("ovf_cpu_rst_held", {31'b0, cpu_rst2}, 32'd1);
    end
    ld_valid2 = 1'b0;
    chk("ovf_flag", {31'b0, ld_overflow2}, 32'd1);
    chk("ovf_cpu_rst", {31'b0, cpu_rst2}, 32'd0);
    chk("ovf_ready", {31'b0, ld_ready2}, 32'd0);
    addr_imem2 = 32'h00400000;
    #1 chk("ovf_word0", data_imem2, 32'd1);
    addr_imem2 = 32'h0040000C;
    #1 chk("ovf_word3", data_imem2, 32'd4);
    addr_imem2 = 32'h00400010;
    #1 chk("ovf_miss", data_imem2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
